// File: rtl/det_sched_pkg.sv
// rtl/det_sched_pkg.sv - shared state encoding and default geometry for det_sched
package det_sched_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_WIN_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/det_sched_win_match.sv
// rtl/det_sched_win_match.sv - sliding bit window compared against a latched pattern
import det_sched_pkg::*;

module win_match #(
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    input  logic [WIN_W-1:0] pat,
    output logic             hit
);

    localparam int FW = $clog2(WIN_W + 1);

    logic [WIN_W-1:0] window;
    logic [WIN_W-1:0] window_nxt;
    logic [FW-1:0]    fill;

    assign window_nxt = {window[WIN_W-2:0], bit_in};

    // A window only counts once it holds WIN_W bits of the current word.
    assign hit = shift_en && (fill >= FW'(WIN_W - 1)) && (window_nxt == pat);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            window <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            window <= window_nxt;
            if (fill != FW'(WIN_W))
                fill <= fill + FW'(1);
        end
    end

endmodule

// File: rtl/det_sched.sv
// rtl/det_sched.sv - round-robin two-requester word scheduler counting pattern windows
import det_sched_pkg::*;

module det_sched #(
    parameter int WORD_W = DEF_WORD_W,
    parameter int WIN_W  = DEF_WIN_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [1:0]                   req,
    input  logic [WORD_W-1:0]            data0,
    input  logic [WORD_W-1:0]            data1,
    input  logic [WIN_W-1:0]             pat,
    output logic [1:0]                   grant,
    output logic                         busy,
    output logic                         done,
    output logic                         done_id,
    output logic [$clog2(WORD_W+1)-1:0]  match_cnt
);

    localparam int CW = $clog2(WORD_W + 1);

    state_t            state;
    logic [WORD_W-1:0] word_q;
    logic [WIN_W-1:0]  pat_q;
    logic              cur_id;
    logic              prio;
    logic [CW-1:0]     bit_cnt;
    logic [CW-1:0]     cnt;
    logic              winner;
    logic              load;
    logic              hit;

    // prio names the requester that wins a tie; it flips away from whoever was served last.
    assign winner = (req == 2'b11) ? prio : req[1];
    assign load   = (state == ST_IDLE) && (req != 2'b00);

    win_match #(.WIN_W(WIN_W)) u_win_match (
        .clk      (clk),
        .reset    (reset),
        .clr      (load),
        .shift_en (state == ST_SHIFT),
        .bit_in   (word_q[WORD_W-1]),
        .pat      (pat_q),
        .hit      (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            word_q    <= '0;
            pat_q     <= '0;
            cur_id    <= 1'b0;
            prio      <= 1'b0;
            bit_cnt   <= '0;
            cnt       <= '0;
            grant     <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            match_cnt <= '0;
        end else begin
            grant <= 2'b00;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        word_q  <= winner ? data1 : data0;
                        pat_q   <= pat;
                        cur_id  <= winner;
                        bit_cnt <= '0;
                        cnt     <= '0;
                        grant   <= id_onehot(winner);
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    word_q  <= {word_q[WORD_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CW'(1);
                    cnt     <= cnt + CW'(hit);
                    if (bit_cnt == CW'(WORD_W - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    done_id   <= cur_id;
                    match_cnt <= cnt;
                    prio      <= ~cur_id;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_det_sched.sv
// tb/tb_det_sched.sv - directed and randomized checks of det_sched against a word-level model
module tb_det_sched;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    req = 2'b00;
    logic [W-1:0]  data0 = '0;
    logic [W-1:0]  data1 = '0;
    logic [N-1:0]  pat = '0;
    logic [1:0]    grant;
    logic          busy;
    logic          done;
    logic          done_id;
    logic [CW-1:0] match_cnt;

    int   checks = 0;
    int   errors = 0;
    logic tb_prio = 1'b0;

    always #5 clk = ~clk;

    det_sched #(.WORD_W(W), .WIN_W(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .pat       (pat),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .match_cnt (match_cnt)
    );

    function automatic int ref_count(input logic [W-1:0] w, input logic [N-1:0] p);
        int c;
        logic [W-1:0] s;
        c = 0;
        for (int k = N; k <= W; k++) begin
            s = w >> (W - k);
            if (s[N-1:0] == p) c++;
        end
        return c;
    endfunction

    function automatic logic pick(input logic [1:0] r, input logic pr);
        return (r == 2'b11) ? pr : r[1];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tb_prio = 1'b0;
    endtask

    // mode 0: leave inputs alone, 1: scramble data/pat after grant, 2: zero pat after grant
    task automatic serve(input logic exp_id, input int exp_cnt, input bit keep, input int mode);
        int n;
        int lat;
        n = 0;
        while (grant == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_gap", n, 1);
        check("grant", grant, exp_id ? 2'b10 : 2'b01);
        check("busy_at_grant", busy, 1);
        if (!keep) req[exp_id] = 1'b0;
        if (mode == 1) begin
            data0 = W'($urandom);
            data1 = W'($urandom);
            pat   = N'($urandom);
        end else if (mode == 2) begin
            pat = '0;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 30);
        check("done_latency", lat, W + 1);
        check("done_id", done_id, exp_id);
        check("match_cnt", match_cnt, exp_cnt);
        check("busy_at_done", busy, 0);
        tb_prio = ~exp_id;
    endtask

    initial begin
        logic [1:0] r;
        logic       id;
        int         n;
        bit         seen;

        do_reset();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_match_cnt", match_cnt, 0);

        data0 = 8'b0110_1100; pat = 3'b011; req = 2'b01;
        serve(1'b0, ref_count(data0, pat), 0, 0);

        data1 = 8'hFF; pat = 3'b111; req = 2'b10;
        serve(1'b1, ref_count(data1, pat), 0, 0);
        data1 = 8'h00; pat = 3'b111; req = 2'b10;
        serve(1'b1, ref_count(data1, pat), 0, 0);
        @(negedge clk);
        check("hold_done", done, 0);
        check("hold_match_cnt", match_cnt, 0);
        check("hold_done_id", done_id, 1);

        do_reset();
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            data0 = W'($urandom); data1 = W'($urandom); pat = N'($urandom);
            id = pick(req, tb_prio);
            serve(id, ref_count(id ? data1 : data0, pat), 1, 0);
        end
        req = 2'b00;

        data0 = 8'b0110_1100; pat = 3'b110; req = 2'b01;
        serve(1'b0, ref_count(data0, 3'b110), 0, 2);

        data0 = 8'b0000_0001; pat = 3'b011; req = 2'b01;
        serve(1'b0, ref_count(data0, pat), 0, 0);
        data0 = 8'b1000_0000; req = 2'b01;
        serve(1'b0, ref_count(data0, pat), 0, 0);

        data0 = 8'hA5; pat = 3'b101; req = 2'b01;
        n = 0;
        while (grant == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_grant", grant, 2'b01);
        req = 2'b00;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tb_prio = 1'b0;
        check("abort_grant_rst", grant, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_done_id", done_id, 0);
        check("abort_match_cnt", match_cnt, 0);
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        data0 = 8'b0111_0111; pat = 3'b111; req = 2'b01;
        serve(1'b0, ref_count(data0, pat), 0, 0);

        for (int i = 0; i < 30; i++) begin
            r = 2'($urandom_range(1, 3));
            data0 = W'($urandom); data1 = W'($urandom); pat = N'($urandom);
            id = pick(r, tb_prio);
            req = r;
            serve(id, ref_count(id ? data1 : data0, pat), 0, 1);
        end
        req = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
